aes_inv_cipher_iter: RTL and testbench

- Iterative AES inverse cipher (decryption) core.
- Complementary direction to the encrypt-side round datapath (ShiftRows/SubBytes/MixColumns).
- Executes one inverse round per clock: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
- Round keys come from an external key-schedule register file via a combinational index/data port.
- Valid/ready handshakes on input ciphertext and output plaintext.

---
 rtl/aes_pkg.sv | 68 ++++++
 rtl/aes_inv_sbox.sv | 29 ++
 rtl/aes_inv_cipher_iter.sv | 126 ++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher types, constants and GF(2^8) round helpers.
// Byte i (row i%4, column i/4) sits at bits [127-8i -: 8] of aes_state_t.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aes_fsm_e;

  function automatic logic [7:0] get_b(aes_state_t s, int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by any 4-bit constant; only 9/b/d/e are used by InvMixColumns.
  function automatic logic [7:0] gmul(logic [7:0] a, logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
           (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic aes_state_t inv_shift_rows(aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = get_b(s, 4*((c - r + 4) % 4) + r);
      end
    end
    return o;
  endfunction

  function automatic aes_state_t inv_mix_columns(aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_b(s, 4*c);
      a1 = get_b(s, 4*c+1);
      a2 = get_b(s, 4*c+2);
      a3 = get_b(s, 4*c+3);
      o[127-8*(4*c)   -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[127-8*(4*c+1) -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[127-8*(4*c+2) -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

  function automatic aes_state_t add_round_key(aes_state_t s, aes_state_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup, zero latency, no flow control.
module aes_inv_sbox (
  input  logic [7:0] in_byte_i,
  output logic [7:0] out_byte_o
);

  // Entry x lives at bits [2047-8x -: 8], i.e. top index {~x, 3'b111}.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_byte_o = INV_SBOX[{~in_byte_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES decryption, one inverse round per clock; pt valid NR cycles after accept,
// held under out_ready backpressure, no accept until retire. Optional abort: AES_INV_CIPHER_ABORT_EN.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_INV_CIPHER_ABORT_EN
  input  logic         abort,
`endif
  output logic [127:0] pt
);

  if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  aes_fsm_e   st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  aes_state_t s_q, s_d;
  logic       abort_w;

`ifdef AES_INV_CIPHER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  aes_state_t isr, isb, rnd_out, fin_out;

  assign isr = inv_shift_rows(s_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .in_byte_i (isr[127-8*i -: 8]),
      .out_byte_o(isb[127-8*i -: 8])
    );
  end

  assign rnd_out = inv_mix_columns(add_round_key(isb, rk));
  assign fin_out = add_round_key(isb, rk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      cnt_q <= 4'(NR);
      s_q   <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      s_q   <= s_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    s_d   = s_q;
    case (st_q)
      ST_IDLE: begin
        if (in_valid && !abort_w) begin
          s_d   = add_round_key(ct, rk);
          cnt_d = 4'(NR - 1);
          st_d  = ST_ROUND;
        end
      end
      ST_ROUND: begin
        s_d = rnd_out;
        if (cnt_q == 4'd1) begin
          cnt_d = 4'd0;
          st_d  = ST_FINAL;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_FINAL: begin
        s_d  = fin_out;
        st_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          cnt_d = 4'(NR);
          st_d  = ST_IDLE;
        end
      end
      default: begin
        cnt_d = 4'(NR);
        st_d  = ST_IDLE;
      end
    endcase
    // Abort outranks retire and any in-flight round; the partial state is wiped.
    if (abort_w && st_q != ST_IDLE) begin
      st_d  = ST_IDLE;
      cnt_d = 4'(NR);
      s_d   = '0;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'd0;
    case (st_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        rk_idx   = 4'(NR);
      end
      ST_ROUND: rk_idx = cnt_q;
      ST_FINAL: rk_idx = 4'd0;
      ST_DONE:  out_valid = 1'b1;
      default:  rk_idx = 4'd0;
    endcase
  end

  assign pt = s_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: NR=10 and NR=14 instances, FIPS-197 vectors plus random
// blocks checked against a byte-array InvCipher model with an arithmetically derived S-box.
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] ct        [2];
  logic [3:0]   rk_idx    [2];
  logic [127:0] rk        [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] pt        [2];
`ifdef AES_INV_CIPHER_ABORT_EN
  logic         abort     [2];
`endif

  logic [127:0] rks [2][16];
  assign rk[0] = rks[0][rk_idx[0]];
  assign rk[1] = rks[1][rk_idx[1]];

  aes_inv_cipher_iter #(.NR(10)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .ct(ct[0]), .rk_idx(rk_idx[0]), .rk(rk[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
`ifdef AES_INV_CIPHER_ABORT_EN
    .abort(abort[0]),
`endif
    .pt(pt[0])
  );

  aes_inv_cipher_iter #(.NR(14)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .ct(ct[1]), .rk_idx(rk_idx[1]), .rk(rk[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
`ifdef AES_INV_CIPHER_ABORT_EN
    .abort(abort[1]),
`endif
    .pt(pt[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic int nr_of(input int d);
    return (d != 0) ? 14 : 10;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  task automatic init_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(x));
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // 128-bit keys sit in key[255:128].
  task automatic load_key(input int d, input logic [255:0] key);
    int nk = (d != 0) ? 8 : 4;
    int nr = nk + 6;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rks[d][r] = '0;
    for (int r = 0; r <= nr; r++) rks[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] bget(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] model_dec(input int d, input logic [127:0] c);
    int nr = nr_of(d);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = bget(c, i) ^ bget(rks[d][nr], i);
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int c2 = 0; c2 < 4; c2++)
        for (int r = 0; r < 4; r++)
          t[4*((c2 + r) % 4) + r] = isbox_t[s[4*c2 + r]];
      for (int i = 0; i < 16; i++) t[i] ^= bget(rks[d][rnd], i);
      if (rnd > 0) begin
        for (int c2 = 0; c2 < 4; c2++) begin
          s[4*c2]   = gf_mul(t[4*c2], 8'h0e) ^ gf_mul(t[4*c2+1], 8'h0b) ^ gf_mul(t[4*c2+2], 8'h0d) ^ gf_mul(t[4*c2+3], 8'h09);
          s[4*c2+1] = gf_mul(t[4*c2], 8'h09) ^ gf_mul(t[4*c2+1], 8'h0e) ^ gf_mul(t[4*c2+2], 8'h0b) ^ gf_mul(t[4*c2+3], 8'h0d);
          s[4*c2+2] = gf_mul(t[4*c2], 8'h0d) ^ gf_mul(t[4*c2+1], 8'h09) ^ gf_mul(t[4*c2+2], 8'h0e) ^ gf_mul(t[4*c2+3], 8'h0b);
          s[4*c2+3] = gf_mul(t[4*c2], 8'h0b) ^ gf_mul(t[4*c2+1], 8'h0d) ^ gf_mul(t[4*c2+2], 8'h09) ^ gf_mul(t[4*c2+3], 8'h0e);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start(input int d, input logic [127:0] c, input string tag);
    int k = 0;
    while (in_ready[d] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rdy"}, 128'(in_ready[d]), 128'd1);
    check({tag, "_idx_idle"}, 128'(rk_idx[d]), 128'(nr_of(d)));
    in_valid[d] = 1'b1;
    ct[d]       = c;
    @(negedge clk);
    in_valid[d] = 1'b0;
    ct[d]       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic finish(input int d, input logic [127:0] exp, input string tag);
    int nr = nr_of(d);
    logic ok = 1'b1;
    for (int j = 1; j <= nr; j++) begin
      if (rk_idx[d] !== 4'(nr - j) || out_valid[d] !== 1'b0 || in_ready[d] !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check({tag, "_seq"}, 128'(ok), 128'd1);
    check({tag, "_vld"}, 128'(out_valid[d]), 128'd1);
    check({tag, "_pt"}, pt[d], exp);
    if (out_ready[d]) begin
      @(negedge clk);
      check({tag, "_retire"}, 128'({out_valid[d], in_ready[d]}), 128'b01);
    end
  endtask

  typedef struct packed {
    logic         d;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  initial begin
    vec_t vecs [3];
    logic [127:0] a, b, e_a, e_b;
    logic hold_ok;
    int k;

    vecs[0] = '{1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
    vecs[1] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};

    init_tables();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; in_valid[d] = 1'b0; ct[d] = '0; out_ready[d] = 1'b1;
`ifdef AES_INV_CIPHER_ABORT_EN
      abort[d] = 1'b0;
`endif
      for (int r = 0; r < 16; r++) rks[d][r] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_in_ready", d), 128'(in_ready[d]), 128'd1);
      check($sformatf("rst%0d_out_valid", d), 128'(out_valid[d]), 128'd0);
      check($sformatf("rst%0d_pt", d), pt[d], 128'd0);
      check($sformatf("rst%0d_rk_idx", d), 128'(rk_idx[d]), 128'(nr_of(d)));
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Known-answer vectors.
    for (int v = 0; v < 3; v++) begin
      load_key(int'(vecs[v].d), vecs[v].key);
      start(int'(vecs[v].d), vecs[v].ct, $sformatf("kat%0d", v));
      finish(int'(vecs[v].d), vecs[v].pt, $sformatf("kat%0d", v));
    end

    // Random keys and ciphertexts on both key sizes.
    for (int n = 0; n < 6; n++) begin
      int d = n % 2;
      load_key(d, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      a = {$urandom, $urandom, $urandom, $urandom};
      start(d, a, $sformatf("rnd%0d", n));
      finish(d, model_dec(d, a), $sformatf("rnd%0d", n));
    end

    // Backpressure: pt held, second ct offered throughout, taken one cycle after retire.
    load_key(0, {$urandom, $urandom, $urandom, $urandom, 128'h0});
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    e_a = model_dec(0, a);
    e_b = model_dec(0, b);
    out_ready[0] = 1'b0;
    start(0, a, "bp1");
    finish(0, e_a, "bp1");
    in_valid[0] = 1'b1;
    ct[0] = b;
    hold_ok = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b1 || pt[0] !== e_a || in_ready[0] !== 1'b0) hold_ok = 1'b0;
    end
    check("bp_hold", 128'(hold_ok), 128'd1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_retire", 128'({out_valid[0], in_ready[0]}), 128'b01);
    @(negedge clk);
    in_valid[0] = 1'b0;
    finish(0, e_b, "bp2");

    // Reset in ROUND at cnt=5, then a clean block.
    a = {$urandom, $urandom, $urandom, $urandom};
    start(0, a, "rstmid");
    k = 0;
    while (rk_idx[0] !== 4'd5 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rstmid_reach_cnt5", 128'(rk_idx[0]), 128'd5);
    rst_n[0] = 1'b0;
    #1;
    check("rstmid_flags", 128'({out_valid[0], in_ready[0]}), 128'b01);
    check("rstmid_pt", pt[0], 128'd0);
    check("rstmid_idx", 128'(rk_idx[0]), 128'd10);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("rstmid_still_idle", 128'({out_valid[0], in_ready[0]}), 128'b01);
    b = {$urandom, $urandom, $urandom, $urandom};
    start(0, b, "postrst");
    finish(0, model_dec(0, b), "postrst");

`ifdef AES_INV_CIPHER_ABORT_EN
    // Abort in FINAL: back to IDLE next cycle, state cleared, never valid.
    a = {$urandom, $urandom, $urandom, $urandom};
    start(0, a, "abort");
    k = 0;
    while (rk_idx[0] !== 4'd0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("abort_in_final", 128'({rk_idx[0], out_valid[0]}), 128'd0);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort_idle", 128'({out_valid[0], in_ready[0]}), 128'b01);
    check("abort_pt", pt[0], 128'd0);
    @(negedge clk);
    check("abort_no_valid", 128'(out_valid[0]), 128'd0);
    // Abort in IDLE blocks a same-cycle accept.
    abort[0] = 1'b1;
    in_valid[0] = 1'b1;
    ct[0] = a;
    @(negedge clk);
    abort[0] = 1'b0;
    in_valid[0] = 1'b0;
    check("abort_blocks_accept", 128'({in_ready[0], rk_idx[0]}), 128'({1'b1, 4'd10}));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
